// File: rtl/pulse_width_meter_if.sv
// Read-side bus of the pulse width meter: channel select, read strobe,
// registered read data and the summary interrupt.
interface pulse_width_meter_if #(
  parameter int W     = 24,
  parameter int SEL_W = 1
);
  logic [SEL_W-1:0] sel;
  logic             rd;
  logic [W-1:0]     rd_high;
  logic [W-1:0]     rd_low;
  logic             rd_valid;
  logic [3:0]       rd_flags;
  logic             irq;

  modport master (
    output sel, rd,
    input  rd_high, rd_low, rd_valid, rd_flags, irq
  );

  modport slave (
    input  sel, rd,
    output rd_high, rd_low, rd_valid, rd_flags, irq
  );
endinterface

// File: rtl/pulse_width_meter.sv
// Multi-channel pulse width meter: measures high and low phase widths of
// asynchronous inputs in tick units and exposes them through a read port.
module pulse_width_meter #(
  parameter int CH    = 2,
  parameter int W     = 24,
  parameter int SEL_W = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 tick,
  input  logic [CH-1:0]        en,
  input  logic [CH-1:0]        cnt,
  pulse_width_meter_if.slave   bus
);

  localparam logic [W-1:0] CNT_MAX = '1;
  localparam logic [W-1:0] CNT_ONE = W'(1);

  logic [CH-1:0] sync1_q, sync1_d;
  logic [CH-1:0] sync2_q, sync2_d;
  logic [CH-1:0] sdly_q, sdly_d;
  logic [2:0]    prime_q, prime_d;

  logic [W-1:0]  high_cnt_q [CH];
  logic [W-1:0]  high_cnt_d [CH];
  logic [W-1:0]  low_cnt_q  [CH];
  logic [W-1:0]  low_cnt_d  [CH];
  logic [W-1:0]  cap_high_q [CH];
  logic [W-1:0]  cap_high_d [CH];
  logic [W-1:0]  cap_low_q  [CH];
  logic [W-1:0]  cap_low_d  [CH];

  logic [CH-1:0] armed_h_q, armed_h_d;
  logic [CH-1:0] armed_l_q, armed_l_d;
  logic [CH-1:0] new_h_q, new_h_d;
  logic [CH-1:0] new_l_q, new_l_d;
  logic [CH-1:0] ovf_h_q, ovf_h_d;
  logic [CH-1:0] ovf_l_q, ovf_l_d;

  logic [W-1:0]  rd_high_q, rd_high_d;
  logic [W-1:0]  rd_low_q, rd_low_d;
  logic [3:0]    rd_flags_q, rd_flags_d;
  logic          rd_valid_q, rd_valid_d;
  logic          irq_q, irq_d;

  logic [31:0]   sel_ext;
  logic [CH-1:0] rise, fall, rd_hit;

  // The synchronizer restarts from 0 after reset, so the first apparent rise
  // is an artifact; edges are ignored until all three stages hold real samples.
  assign rise    = {CH{prime_q[2]}} & sync2_q & ~sdly_q;
  assign fall    = {CH{prime_q[2]}} & ~sync2_q & sdly_q;
  assign sel_ext = 32'(bus.sel);

  always_comb begin
    rd_hit = '0;
    for (int i = 0; i < CH; i++) begin
      rd_hit[i] = bus.rd && (sel_ext == 32'(i));
    end
  end

  always_comb begin
    sync1_d    = cnt;
    sync2_d    = sync1_q;
    sdly_d     = sync2_q;
    prime_d    = {prime_q[1:0], 1'b1};
    high_cnt_d = high_cnt_q;
    low_cnt_d  = low_cnt_q;
    cap_high_d = cap_high_q;
    cap_low_d  = cap_low_q;
    armed_h_d  = armed_h_q;
    armed_l_d  = armed_l_q;
    new_h_d    = new_h_q;
    new_l_d    = new_l_q;
    ovf_h_d    = ovf_h_q;
    ovf_l_d    = ovf_l_q;

    for (int i = 0; i < CH; i++) begin
      // Read-clear comes first so that any set below overrides it.
      if (rd_hit[i]) begin
        new_h_d[i] = 1'b0;
        new_l_d[i] = 1'b0;
        ovf_h_d[i] = 1'b0;
        ovf_l_d[i] = 1'b0;
      end

      if (en[i]) begin
        if (fall[i]) begin
          high_cnt_d[i] = '0;
          armed_l_d[i]  = 1'b1;
          if (armed_h_q[i]) begin
            cap_high_d[i] = high_cnt_q[i];
            new_h_d[i]    = 1'b1;
            ovf_h_d[i]    = (high_cnt_q[i] == CNT_MAX);
          end
        end else if (tick && sync2_q[i]) begin
          if (high_cnt_q[i] == CNT_MAX) begin
            ovf_h_d[i] = 1'b1;
          end else begin
            high_cnt_d[i] = high_cnt_q[i] + CNT_ONE;
          end
        end

        if (rise[i]) begin
          low_cnt_d[i] = '0;
          armed_h_d[i] = 1'b1;
          if (armed_l_q[i]) begin
            cap_low_d[i] = low_cnt_q[i];
            new_l_d[i]   = 1'b1;
            ovf_l_d[i]   = (low_cnt_q[i] == CNT_MAX);
          end
        end else if (tick && !sync2_q[i]) begin
          if (low_cnt_q[i] == CNT_MAX) begin
            ovf_l_d[i] = 1'b1;
          end else begin
            low_cnt_d[i] = low_cnt_q[i] + CNT_ONE;
          end
        end
      end else begin
        high_cnt_d[i] = '0;
        low_cnt_d[i]  = '0;
        armed_h_d[i]  = 1'b0;
        armed_l_d[i]  = 1'b0;
      end
    end
  end

  // Read data returns the pre-update capture registers and flags.
  always_comb begin
    rd_high_d  = rd_high_q;
    rd_low_d   = rd_low_q;
    rd_flags_d = rd_flags_q;
    rd_valid_d = bus.rd;
    irq_d      = |{new_h_q, new_l_q};
    if (bus.rd) begin
      rd_high_d  = '0;
      rd_low_d   = '0;
      rd_flags_d = '0;
      for (int i = 0; i < CH; i++) begin
        if (sel_ext == 32'(i)) begin
          rd_high_d  = cap_high_q[i];
          rd_low_d   = cap_low_q[i];
          rd_flags_d = {ovf_h_q[i], ovf_l_q[i], new_h_q[i], new_l_q[i]};
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      sdly_q     <= '0;
      prime_q    <= '0;
      high_cnt_q <= '{default: '0};
      low_cnt_q  <= '{default: '0};
      cap_high_q <= '{default: '0};
      cap_low_q  <= '{default: '0};
      armed_h_q  <= '0;
      armed_l_q  <= '0;
      new_h_q    <= '0;
      new_l_q    <= '0;
      ovf_h_q    <= '0;
      ovf_l_q    <= '0;
      rd_high_q  <= '0;
      rd_low_q   <= '0;
      rd_flags_q <= '0;
      rd_valid_q <= 1'b0;
      irq_q      <= 1'b0;
    end else begin
      sync1_q    <= sync1_d;
      sync2_q    <= sync2_d;
      sdly_q     <= sdly_d;
      prime_q    <= prime_d;
      high_cnt_q <= high_cnt_d;
      low_cnt_q  <= low_cnt_d;
      cap_high_q <= cap_high_d;
      cap_low_q  <= cap_low_d;
      armed_h_q  <= armed_h_d;
      armed_l_q  <= armed_l_d;
      new_h_q    <= new_h_d;
      new_l_q    <= new_l_d;
      ovf_h_q    <= ovf_h_d;
      ovf_l_q    <= ovf_l_d;
      rd_high_q  <= rd_high_d;
      rd_low_q   <= rd_low_d;
      rd_flags_q <= rd_flags_d;
      rd_valid_q <= rd_valid_d;
      irq_q      <= irq_d;
    end
  end

  assign bus.rd_high  = rd_high_q;
  assign bus.rd_low   = rd_low_q;
  assign bus.rd_flags = rd_flags_q;
  assign bus.rd_valid = rd_valid_q;
  assign bus.irq      = irq_q;

endmodule

// File: tb/tb_pulse_width_meter.sv
// Scoreboard bench for pulse_width_meter: directed scenarios plus random
// traffic, checked against a phase-width reference model.
module tb_pulse_width_meter;

  localparam int CH    = 2;
  localparam int W     = 8;
  localparam int SEL_W = 2;
  localparam int MAXV  = (1 << W) - 1;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick;
  logic [CH-1:0] en;
  logic [CH-1:0] cnt;

  pulse_width_meter_if #(.W(W), .SEL_W(SEL_W)) bus ();

  pulse_width_meter #(.CH(CH), .W(W), .SEL_W(SEL_W)) dut (
    .clk   (clk),
    .reset (reset),
    .tick  (tick),
    .en    (en),
    .cnt   (cnt),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [3:0]   fl;
  } resp_t;

  resp_t exp_q[$];
  resp_t mon_e;
  int    checks   = 0;
  int    failures = 0;

  // Reference model: raw unbounded tick counts per phase, clipped at capture.
  int run_hi [CH];
  int run_lo [CH];
  int cap_h  [CH];
  int cap_l  [CH];
  bit armed_h[CH], armed_l[CH];
  bit new_h[CH], new_l[CH], ovf_h[CH], ovf_l[CH];
  bit h1[CH], h2[CH], h3[CH];
  int since_rst = 0;
  bit irq_exp   = 1'b0;

  logic [CH-1:0] en_v  = '0;
  logic [CH-1:0] cnt_v = '0;
  int tick_div = 1;
  int tick_ph  = 0;

  function automatic void check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endfunction

  task automatic model_step(input bit r, input bit t, input logic [CH-1:0] e,
                            input logic [CH-1:0] c, input bit rd, input logic [SEL_W-1:0] s);
    resp_t rsp;
    bit    irq_next;
    bit    s_now, s_old, f, rz;
    int    sv;
    sv = int'(s);
    if (r) begin
      for (int ch = 0; ch < CH; ch++) begin
        run_hi[ch] = 0; run_lo[ch] = 0; cap_h[ch] = 0; cap_l[ch] = 0;
        armed_h[ch] = 0; armed_l[ch] = 0;
        new_h[ch] = 0; new_l[ch] = 0; ovf_h[ch] = 0; ovf_l[ch] = 0;
        h1[ch] = 0; h2[ch] = 0; h3[ch] = 0;
      end
      since_rst = 0;
      irq_exp   = 1'b0;
      return;
    end
    irq_next = 1'b0;
    for (int ch = 0; ch < CH; ch++) irq_next |= new_h[ch] | new_l[ch];
    if (rd) begin
      if (sv < CH) begin
        rsp.hi = W'(cap_h[sv]);
        rsp.lo = W'(cap_l[sv]);
        rsp.fl = {ovf_h[sv], ovf_l[sv], new_h[sv], new_l[sv]};
      end else begin
        rsp.hi = '0; rsp.lo = '0; rsp.fl = '0;
      end
      exp_q.push_back(rsp);
    end
    for (int ch = 0; ch < CH; ch++) begin
      s_now = h2[ch];
      s_old = h3[ch];
      f  = (since_rst >= 3) && !s_now && s_old;
      rz = (since_rst >= 3) && s_now && !s_old;
      if (rd && sv == ch) begin
        new_h[ch] = 0; new_l[ch] = 0; ovf_h[ch] = 0; ovf_l[ch] = 0;
      end
      if (e[ch]) begin
        if (f) begin
          if (armed_h[ch]) begin
            cap_h[ch] = (run_hi[ch] > MAXV) ? MAXV : run_hi[ch];
            new_h[ch] = 1;
            ovf_h[ch] = (run_hi[ch] >= MAXV);
          end
          run_hi[ch]  = 0;
          armed_l[ch] = 1;
        end else if (t && s_now) begin
          if (run_hi[ch] >= MAXV) ovf_h[ch] = 1;
          run_hi[ch]++;
        end
        if (rz) begin
          if (armed_l[ch]) begin
            cap_l[ch] = (run_lo[ch] > MAXV) ? MAXV : run_lo[ch];
            new_l[ch] = 1;
            ovf_l[ch] = (run_lo[ch] >= MAXV);
          end
          run_lo[ch]  = 0;
          armed_h[ch] = 1;
        end else if (t && !s_now) begin
          if (run_lo[ch] >= MAXV) ovf_l[ch] = 1;
          run_lo[ch]++;
        end
      end else begin
        run_hi[ch] = 0; run_lo[ch] = 0; armed_h[ch] = 0; armed_l[ch] = 0;
      end
      h3[ch] = h2[ch];
      h2[ch] = h1[ch];
      h1[ch] = c[ch];
    end
    since_rst++;
    irq_exp = irq_next;
  endtask

  // One clock cycle: check irq from the previous edge, drive, update model.
  task automatic apply_stimulus(input bit r, input bit t, input logic [CH-1:0] e,
                                input logic [CH-1:0] c, input bit rd_i, input logic [SEL_W-1:0] s);
    @(negedge clk);
    check_output("irq", {31'b0, bus.irq}, {31'b0, irq_exp});
    reset   = r;
    tick    = t;
    en      = e;
    cnt     = c;
    bus.rd  = rd_i;
    bus.sel = s;
    model_step(r, t, e, c, rd_i, s);
  endtask

  function automatic bit next_tick();
    tick_ph = (tick_ph + 1) % tick_div;
    return (tick_ph == 0);
  endfunction

  task automatic run(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b0, next_tick(), en_v, cnt_v, 1'b0, '0);
  endtask

  task automatic read(input logic [SEL_W-1:0] s);
    apply_stimulus(1'b0, next_tick(), en_v, cnt_v, 1'b1, s);
  endtask

  task automatic do_reset(input int n);
    for (int k = 0; k < n; k++) apply_stimulus(1'b1, 1'b0, en_v, cnt_v, 1'b0, '0);
  endtask

  task automatic check_idle(input string tag);
    check_output({tag, "_rd_high"},  32'(bus.rd_high),  32'h0);
    check_output({tag, "_rd_low"},   32'(bus.rd_low),   32'h0);
    check_output({tag, "_rd_flags"}, 32'(bus.rd_flags), 32'h0);
    check_output({tag, "_rd_valid"}, 32'(bus.rd_valid), 32'h0);
    check_output({tag, "_irq"},      32'(bus.irq),      32'h0);
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0 && bus.rd_valid === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL rd_valid_unexpected: actual=1 required=0 at %0t", $time);
      end else begin
        mon_e = exp_q.pop_front();
        check_output("rd_high",  32'(bus.rd_high),  32'(mon_e.hi));
        check_output("rd_low",   32'(bus.rd_low),   32'(mon_e.lo));
        check_output("rd_flags", 32'(bus.rd_flags), 32'(mon_e.fl));
      end
    end
  end

  initial begin
    reset   = 1'b1;
    tick    = 1'b0;
    en      = '0;
    cnt     = '0;
    bus.rd  = 1'b0;
    bus.sel = '0;

    do_reset(3);
    run(1);
    check_idle("reset");

    $display("[TB] basic high/low capture");
    en_v = 2'b11;
    run(5);
    cnt_v[0] = 1'b1; run(10);
    cnt_v[0] = 1'b0; run(20);
    cnt_v[0] = 1'b1; run(10);
    cnt_v[0] = 1'b0; run(5);
    read(0);
    run(3);

    $display("[TB] enable mid high phase");
    en_v = 2'b01;
    cnt_v[1] = 1'b1; run(5);
    en_v = 2'b11;    run(5);
    cnt_v[1] = 1'b0; run(8);
    cnt_v[1] = 1'b1; run(8);
    cnt_v[1] = 1'b0; run(8);
    read(1);
    run(3);

    $display("[TB] saturation");
    cnt_v[0] = 1'b1; run(300);
    cnt_v[0] = 1'b0; run(5);
    read(0);
    run(1);
    read(0);
    run(3);

    $display("[TB] read colliding with capture");
    cnt_v[0] = 1'b1; run(20);
    cnt_v[0] = 1'b0; run(2);
    read(0);
    run(2);
    read(0);
    run(3);

    $display("[TB] slow tick and out-of-range select");
    tick_div = 3;
    cnt_v[0] = 1'b1; run(30);
    cnt_v[0] = 1'b0; run(30);
    cnt_v[0] = 1'b1; run(30);
    cnt_v[0] = 1'b0; run(10);
    read(0);
    run(2);
    read(3);
    run(3);
    tick_div = 1;

    $display("[TB] reset mid measurement");
    cnt_v[0] = 1'b1; run(20);
    do_reset(2);
    run(1);
    check_idle("post_reset");
    run(10);
    cnt_v[0] = 1'b0; run(10);
    read(0);
    run(2);
    cnt_v[0] = 1'b1; run(15);
    cnt_v[0] = 1'b0; run(10);
    read(0);
    run(3);

    $display("[TB] random traffic");
    for (int k = 0; k < 3000; k++) begin
      bit t, r;
      logic [SEL_W-1:0] s;
      for (int ch = 0; ch < CH; ch++) begin
        if ($urandom_range(0, 7) == 0)   cnt_v[ch] = ~cnt_v[ch];
        if ($urandom_range(0, 199) == 0) en_v[ch]  = ~en_v[ch];
      end
      t = ($urandom_range(0, 3) != 0);
      r = ($urandom_range(0, 5) == 0);
      s = SEL_W'($urandom_range(0, 3));
      apply_stimulus(1'b0, t, en_v, cnt_v, r, s);
    end
    run(5);
    check_output("scoreboard_drain", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pulse_width_meter.md
PULSE_WIDTH_METER -- requirements
Module: pulse_width_meter

Interface
REQ-001 Parameter CH, default 2: number of independent input channels, 1..16.
REQ-002 Parameter W, default 24: width of every counter and capture register, 8..32.
REQ-003 Parameter SEL_W, default 1: width of the channel select; 2^SEL_W >= CH.
REQ-004 clk  in  1  single clock; all state on posedge clk.
REQ-005 reset  in  1  asynchronous, active-high; clears all state immediately.
REQ-006 tick  in  1  count strobe; counters advance only in cycles with tick=1.
REQ-007 en  in  CH  per-channel enable.
REQ-008 cnt  in  CH  asynchronous pulse inputs, one per channel.
REQ-009 sel  in  SEL_W  channel to read.
REQ-010 rd  in  1  one-cycle read strobe.
REQ-011 rd_high  out  W  last captured high-phase width of the selected channel.
REQ-012 rd_low  out  W  last captured low-phase width of the selected channel.
REQ-013 rd_valid  out  1  read data valid; one-cycle pulse.
REQ-014 rd_flags  out  4  {ovf_h, ovf_l, new_h, new_l} of the selected channel.
REQ-015 irq  out  1  OR of all new_h and new_l flags of all channels.

Function
REQ-016 Each cnt bit SHALL pass through a 2-flop synchronizer to give s; a third flop gives s_d; rise = s & ~s_d, fall = ~s & s_d.
REQ-017 When en=1 and tick=1: high_cnt SHALL increment while s=1; low_cnt SHALL increment while s=0.
REQ-018 Each counter SHALL saturate at 2^W-1; an increment attempted at saturation SHALL set the sticky ovf flag for that phase.
REQ-019 On fall: if armed_h, cap_high <= high_cnt, new_h <= 1, ovf_h <= saturation state of high_cnt; high_cnt <= 0; armed_l <= 1.
REQ-020 On rise: if armed_l, cap_low <= low_cnt, new_l <= 1, ovf_l <= saturation state of low_cnt; low_cnt <= 0; armed_h <= 1.
REQ-021 A phase already in progress when en rises SHALL NOT be captured; armed_h and armed_l start at 0.
REQ-022 When en=0: both counters SHALL be held at 0, armed_h and armed_l SHALL be cleared, and captures SHALL be suppressed. cap_*, new_*, and ovf_* SHALL retain their values.
REQ-023 A counter cleared on an edge SHALL NOT also increment in that cycle. The opposite-phase counter SHALL increment in the edge cycle if tick=1.
REQ-024 On rd=1 with sel<CH: rd_high, rd_low, and rd_flags of channel sel SHALL be registered and rd_valid SHALL pulse on the next cycle (latency 1).
REQ-025 On rd=1 with sel>=CH: rd_high, rd_low, and rd_flags SHALL be registered as 0, and rd_valid SHALL still pulse.
REQ-026 rd SHALL clear new_h, new_l, ovf_h, and ovf_l of the selected channel. If a capture sets a flag in the same cycle, the set wins; the returned flags are the pre-clear values.
REQ-027 rd_high, rd_low, and rd_flags SHALL hold their last value when rd=0.
REQ-028 irq SHALL be registered, with 1 cycle of latency from any flag change.

Reset
REQ-029 On reset: all counters, cap_*, flags, armed_*, synchronizer flops, and all outputs SHALL be 0, including rd_valid=0 and irq=0.
REQ-030 Reset asserted mid-measurement SHALL discard the measurement. After release, the first capture per phase SHALL require a full arming edge.

Verification
REQ-031 CH=2, W=24, tick=1 always, en=3: cnt[0] held high 10 clk, low 20 clk, high 10 clk, low. Then rd with sel=0 -> rd_high=10, rd_low=20, rd_flags=4'b0011, rd_valid one cycle later.
REQ-032 en[1] raised while cnt[1]=1, cnt[1] falls, rises, falls -> only the second high phase is captured; new_h=1 and new_l=1 after the second fall.
REQ-033 W=8, cnt[0] high for 300 ticks then falling -> cap_high=255, ovf_h=1. rd clears ovf_h; a following rd returns ovf_h=0.
REQ-034 rd sel=0 in the same cycle a fall on channel 0 captures -> returned new_h=old value; new_h remains 1 afterwards; irq stays 1.
REQ-035 tick asserted every 3rd cycle, cnt[0] high 30 clk -> rd_high=10 (±1 for phase alignment); sel=3 with CH=2 -> all-zero data with rd_valid=1.
REQ-036 Reset pulsed mid high phase, then released -> all outputs 0; the next fall produces no capture; the following full high phase is captured correctly.
